vec3_length_iter: RTL and testbench
===================================

Name: vec3_length_iter

Overview:
- Multi-cycle, area-lean successor to the combinational vec3 length unit used by the ray-marcher SDF/normal stages.
- Computes the Euclidean length |v| or the squared length |v|^2 of a signed fixed-point vec3.
- Uses one shared squaring datapath and a bit-serial restoring square root.
- Adds a valid/ready handshake, run-time mode select, saturation with an overflow flag, and full parametrisation in N/FRAC.

Parameters:
- N, 32: component and result width in bits; components are two's-complement Q(N-FRAC).FRAC.
- FRAC, 24: fractional bits of inputs and outputs.

Ports:
- clk, input, 1: clock; all logic is rising-edge.
- rst, input, 1: synchronous, active-low reset.
- vec, input, vec3 (3 x N): operand with x, y, z signed Q(N-FRAC).FRAC; sampled on the accept cycle only.
- mode, input, 1: 0 = length, 1 = squared length; sampled on the accept cycle.
- in_valid, input, 1: operand valid.
- in_ready, output, 1: unit can accept an operand.
- length, output, N: unsigned Q(N-FRAC).FRAC result; stable while out_valid is high.
- ovf, output, 1: the result saturated; qualified by out_valid.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; in_ready=1; out_valid=0; length=0; ovf=0; internal registers cleared.
  - Applies from any state. An in-flight operation is discarded and produces no output.
- FSM states: IDLE, SQUARE, SQRT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready (accept cycle T0), register vec and mode, then go to SQUARE.
- SQUARE (T1), one cycle:
  - Compute S = x*x + y*y + z*z as an unsigned 2N+2-bit value with 2*FRAC fractional bits. No truncation of the product.
  - mode=1: R = S >> FRAC (truncate). Go to DONE.
  - mode=0: load the radicand S and clear the root and remainder. Go to SQRT.
- SQRT, exactly N+1 cycles (T2..T(N+2)):
  - Restoring digit-by-digit square root. One result bit per cycle, MSB first.
  - R = floor(sqrt(S)), which yields FRAC fractional bits directly.
  - An internal counter runs N down to 0. Go to DONE after the count-0 iteration.
- Saturation:
  - If R > 2^(N-1)-1, then length = 2^(N-1)-1 (the largest positive value, signed-compatible downstream) and ovf=1.
  - Otherwise length = R[N-1:0] and ovf=0.
- DONE:
  - out_valid=1, with length and ovf registered on entry.
  - Hold length, ovf and out_valid unchanged while out_ready=0 (backpressure of any duration).
  - On out_valid&&out_ready, go to IDLE; out_valid drops the next cycle.
- Latency from accept to first out_valid:
  - mode=0: N+3 cycles (35 at N=32).
  - mode=1: 2 cycles.
- Throughput:
  - Non-pipelined; one operation in flight.
  - in_ready=0 in SQUARE, SQRT and DONE.
  - in_ready returns the cycle after the output handshake, so there is no same-cycle output-accept/input-accept.
- Boundaries:
  - A zero vector gives length=0, ovf=0.
  - The most negative component (-2^(N-1)) squares correctly with no sign overflow.
  - in_valid while in_ready=0 is ignored. The upstream must hold the operand.
  - vec/mode changes after T0 do not affect the result.

Test Plan:
- Basic length: N=32, FRAC=24, vec=(3.0,4.0,0.0), mode=0, out_ready=1.
  - Expect length=0x05000000 and ovf=0.
  - out_valid rises exactly 35 cycles after the accept edge and lasts 1 cycle.
- Signed operands with backpressure: vec=(-1.0,2.0,-2.0), mode=0, out_ready=0 for 5 cycles after out_valid, then 1.
  - Expect length=0x03000000 held constant for all 6 valid cycles.
  - in_ready=0 throughout; in_ready=1 on the cycle after the handshake.
- Squared mode:
  - vec=(3.0,4.0,0.0), mode=1: expect length=0x19000000, ovf=0, out_valid 2 cycles after accept.
  - vec=(20.0,18.0,3.0), mode=1 (733 > 127.99): expect length=0x7FFFFFFF, ovf=1.
- Saturation and edge cases:
  - vec=(100.0,100.0,100.0), mode=0 (173.2): expect length=0x7FFFFFFF, ovf=1.
  - vec=(0,0,0): expect length=0, ovf=0.
  - vec=(-128.0,0,0) (0x80000000): expect 0x7FFFFFFF, ovf=1.
- Reset mid-operation:
  - Accept (1.0,2.0,2.0), assert rst=0 for 1 cycle at T10.
  - Expect no out_valid for that operation and in_ready=1 after reset.
  - A new (3,4,0) then returns 0x05000000.
- Protocol and operand capture:
  - Hold in_valid=1 with changing vec during SQRT; these values are ignored.
  - Change vec/mode the cycle after accept; the result still matches the operand sampled at T0.

Source files
------------

// File: rtl/vec3_length_iter.sv
// vec3_length_iter: multi-cycle Euclidean length / squared length of a signed
// fixed-point vec3. One squaring cycle, then an (N+1)-cycle restoring square
// root. Result saturates to the largest positive signed value with an ovf flag.
// vec packing: vec[0] = x, vec[1] = y, vec[2] = z.
module vec3_length_iter #(
  parameter int N    = 32,
  parameter int FRAC = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0][N-1:0] vec,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [N-1:0]      length,
  output logic              ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int SW = 2*N + 2;          // sum-of-squares width
  localparam int RW = N + 4;            // shifted remainder / trial width
  localparam int CW = $clog2(N + 1);    // iteration counter width
  localparam logic [SW-1:0] MAXPOS = {{(SW-N+1){1'b0}}, {(N-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, SQUARE, SQRT, DONE} state_t;

  state_t            r_state, w_state_next;
  logic [2:0][N-1:0] r_vec;
  logic              r_mode;
  logic [SW-1:0]     r_rad;
  logic [N:0]        r_root;
  logic [RW-3:0]     r_rem;
  logic [CW-1:0]     r_cnt;
  logic [N-1:0]      r_length;
  logic              r_ovf;

  logic [2:0][N-1:0]   w_mag;
  logic [2:0][2*N-1:0] w_sq;
  logic [SW-1:0]       w_sum;
  logic [SW-1:0]       w_sq_res;
  logic [RW-1:0]       w_rem_sh;
  logic [RW-1:0]       w_trial;
  logic                w_take;
  logic [RW-3:0]       w_diff;
  logic [RW-3:0]       w_rem_next;
  logic [N:0]          w_root_next;
  logic [SW-1:0]       w_root_ext;

  // Clamp a wide unsigned result to N-bit signed-compatible range; returns {ovf, length}.
  function automatic logic [N:0] saturate(input logic [SW-1:0] r);
    if (r > MAXPOS) return {1'b1, 1'b0, {(N-1){1'b1}}};
    else            return {1'b0, r[N-1:0]};
  endfunction

  // Squaring datapath: magnitudes (the most negative value maps to 2^(N-1) unsigned), squares, sum.
  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      w_mag[i] = r_vec[i][N-1] ? (~r_vec[i] + N'(1)) : r_vec[i];
      w_sq[i]  = {{N{1'b0}}, w_mag[i]} * {{N{1'b0}}, w_mag[i]};
      w_sum    = w_sum + {2'b00, w_sq[i]};
    end
    w_sq_res = w_sum >> FRAC;
  end

  // One restoring square-root step; the difference only needs the low bits because
  // the remainder is bounded by 2*root when the trial subtraction succeeds.
  always_comb begin
    w_rem_sh    = {r_rem, r_rad[SW-1:SW-2]};
    w_trial     = {1'b0, r_root, 2'b01};
    w_take      = (w_rem_sh >= w_trial);
    w_diff      = w_rem_sh[RW-3:0] - w_trial[RW-3:0];
    w_rem_next  = w_take ? w_diff : w_rem_sh[RW-3:0];
    w_root_next = {r_root[N-1:0], w_take};
    w_root_ext  = {{(SW-N-1){1'b0}}, w_root_next};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = SQUARE;
      end
      SQUARE:  w_state_next = r_mode ? DONE : SQRT;
      SQRT:    if (r_cnt == '0) w_state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture, square-root iteration and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vec    <= '0;
      r_mode   <= 1'b0;
      r_rad    <= '0;
      r_root   <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_length <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_vec  <= vec;
            r_mode <= mode;
          end
        end
        SQUARE: begin
          if (r_mode) begin
            {r_ovf, r_length} <= saturate(w_sq_res);
          end else begin
            r_rad  <= w_sum;
            r_root <= '0;
            r_rem  <= '0;
            r_cnt  <= CW'(N);
          end
        end
        SQRT: begin
          r_rad  <= r_rad << 2;
          r_root <= w_root_next;
          r_rem  <= w_rem_next;
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == '0) {r_ovf, r_length} <= saturate(w_root_ext);
        end
        default: ;
      endcase
    end
  end

  assign length = r_length;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_vec3_length_iter.sv
// Directed self-checking bench for vec3_length_iter (N=32, FRAC=24).
// Cycle numbering: the accept cycle is T0; lat counts edges from the accept edge.
module tb_vec3_length_iter;

  localparam int N    = 32;
  localparam int FRAC = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0][N-1:0] vec;
  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      length;
  logic              ovf;
  logic              out_valid;
  logic              out_ready;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  vec3_length_iter #(.N(N), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .vec(vec), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .length(length), .ovf(ovf), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  function automatic logic [N-1:0] q(input int v);
    return N'(v * 16777216);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand; returns #1 after the accept edge (cycle T1).
  task automatic send(input int x, input int y, input int z, input logic m);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    vec[0] = q(x); vec[1] = q(y); vec[2] = q(z);
    mode = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0; vec = '0;
    tick(); tick();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (length !== '0) $display("FAIL reset_length: got %h want 0", length); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else n_pass++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_length();
    int lat;
    send(3, 4, 0, 1'b0);
    wait_out(lat);
    n_checks++; if (lat != 35) $display("FAIL basic_latency: got %0d want 35", lat); else n_pass++;
    n_checks++; if (length !== 32'h05000000) $display("FAIL basic_length: got %h want 05000000", length); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL basic_ovf: got %b want 0", ovf); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_valid_one_cycle: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL basic_ready_back: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_fraction();
    int lat;
    send(1, 1, 0, 1'b0);
    wait_out(lat);
    n_checks++; if (length !== 32'h016A09E6) $display("FAIL sqrt2_length: got %h want 016A09E6", length); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL sqrt2_ovf: got %b want 0", ovf); else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    out_ready = 1'b0;
    send(-1, 2, -2, 1'b0);
    wait_out(lat);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || length !== 32'h03000000 || in_ready !== 1'b0) bad++;
      tick();
    end
    n_checks++; if (bad != 0) $display("FAIL bp_hold: got %0d bad cycles want 0", bad); else n_pass++;
    out_ready = 1'b1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid6: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (length !== 32'h03000000) $display("FAIL bp_length: got %h want 03000000", length); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", in_ready); else n_pass++;
    tick();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_valid_drop: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_squared();
    int lat;
    send(3, 4, 0, 1'b1);
    wait_out(lat);
    n_checks++; if (lat != 2) $display("FAIL sq_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (length !== 32'h19000000) $display("FAIL sq_length: got %h want 19000000", length); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL sq_ovf: got %b want 0", ovf); else n_pass++;
    tick();
    send(20, 18, 3, 1'b1);
    wait_out(lat);
    n_checks++; if (length !== 32'h7FFFFFFF) $display("FAIL sq_sat_length: got %h want 7FFFFFFF", length); else n_pass++;
    n_checks++; if (ovf !== 1'b1) $display("FAIL sq_sat_ovf: got %b want 1", ovf); else n_pass++;
    tick();
  endtask

  task automatic test_saturation();
    int lat;
    send(100, 100, 100, 1'b0);
    wait_out(lat);
    n_checks++; if (length !== 32'h7FFFFFFF) $display("FAIL sat_length: got %h want 7FFFFFFF", length); else n_pass++;
    n_checks++; if (ovf !== 1'b1) $display("FAIL sat_ovf: got %b want 1", ovf); else n_pass++;
    tick();
    send(0, 0, 0, 1'b0);
    wait_out(lat);
    n_checks++; if (length !== '0) $display("FAIL zero_length: got %h want 0", length); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL zero_ovf: got %b want 0", ovf); else n_pass++;
    tick();
    send(-128, 0, 0, 1'b0);
    wait_out(lat);
    n_checks++; if (length !== 32'h7FFFFFFF) $display("FAIL minneg_length: got %h want 7FFFFFFF", length); else n_pass++;
    n_checks++; if (ovf !== 1'b1) $display("FAIL minneg_ovf: got %b want 1", ovf); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    send(1, 2, 2, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", in_ready); else n_pass++;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      tick();
    end
    n_checks++; if (seen != 0) $display("FAIL midrst_no_output: got %0d valid cycles want 0", seen); else n_pass++;
    send(3, 4, 0, 1'b0);
    wait_out(lat);
    n_checks++; if (length !== 32'h05000000) $display("FAIL midrst_next: got %h want 05000000", length); else n_pass++;
    tick();
  endtask

  task automatic test_protocol();
    int lat;
    int rdy_seen;
    send(3, 4, 0, 1'b0);
    vec[0] = q(100); vec[1] = q(100); vec[2] = q(100);
    mode = 1'b1;
    in_valid = 1'b1;
    lat = 1;
    rdy_seen = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen++;
      vec[0] = q(lat); vec[1] = q(-lat);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    n_checks++; if (rdy_seen != 0) $display("FAIL proto_ready_low: got %0d ready cycles want 0", rdy_seen); else n_pass++;
    n_checks++; if (lat != 35) $display("FAIL proto_latency: got %0d want 35", lat); else n_pass++;
    n_checks++; if (length !== 32'h05000000) $display("FAIL proto_length: got %h want 05000000", length); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL proto_ovf: got %b want 0", ovf); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL proto_no_reaccept: got %b want 0", out_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_length();
    test_fraction();
    test_backpressure();
    test_squared();
    test_saturation();
    test_reset_mid();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
